// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
// Build option: ARB_PKT_LOCK_EN enables packet-level grant locking.
package stream_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int NCH_DEF = 4;

  // Channel-index width, never narrower than one bit.
  function automatic int id_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo NCH.
// Uses a double-width masked priority encoder.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int IDW = id_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] last,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id
);

  logic [NCH-1:0]   mask;
  logic [2*NCH-1:0] dbl;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
      assign mask[gi] = (gi > int'(last));
    end
  endgenerate

  // Lower half holds only requesters above 'last'; upper half supplies the wrap-around.
  assign dbl     = {req, req & mask};
  assign gnt_vld = |req;

  always_comb begin
    gnt_id = '0;
    for (int k = 2*NCH-1; k >= 0; k--) begin
      if (dbl[k]) gnt_id = IDW'(k % NCH);
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI-Stream output among NCH requesters.
// Build option: define ARB_PKT_LOCK_EN to hold the grant from first beat to tlast.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int n   = 5,
  parameter int nb  = n*8,
  parameter int NCH = NCH_DEF,
  parameter int IDW = id_w(NCH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NCH*nb-1:0] s_tdata,
  input  logic [NCH-1:0]    s_tvalid,
  input  logic [NCH-1:0]    s_tlast,
  output logic [NCH-1:0]    s_tready,
  output logic [nb-1:0]     m_tdata,
  output logic              m_tlast,
  output logic [IDW-1:0]    m_tid,
  output logic              m_tvalid,
  input  logic              m_tready
);

  logic           out_en;
  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] last_ptr;
  logic [IDW-1:0] gnt;
  logic           sel_vld;
  logic           accept;
  logic           sel_last;
  logic [nb-1:0]  sel_data;

  rr_pick #(.NCH(NCH), .IDW(IDW)) u_pick (
    .req     (s_tvalid),
    .last    (last_ptr),
    .gnt_vld (pick_vld),
    .gnt_id  (pick_id)
  );

`ifdef ARB_PKT_LOCK_EN
  arb_state_t     state;
  logic [IDW-1:0] lock_id;

  // While locked the owner keeps the grant even when it has nothing to send.
  assign gnt     = (state == ARB_LOCKED) ? lock_id : pick_id;
  assign sel_vld = (state == ARB_LOCKED) | pick_vld;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ARB_IDLE;
      lock_id  <= '0;
      last_ptr <= IDW'(NCH-1);
    end else if (accept) begin
      if (sel_last) begin
        state    <= ARB_IDLE;
        last_ptr <= gnt;
      end else if (state == ARB_IDLE) begin
        state   <= ARB_LOCKED;
        lock_id <= gnt;
      end
    end
  end
`else
  assign gnt     = pick_id;
  assign sel_vld = pick_vld;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_ptr <= IDW'(NCH-1);
    end else if (accept) begin
      last_ptr <= gnt;
    end
  end
`endif

  assign out_en = ~m_tvalid | m_tready;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign s_tready[gi] = aresetn & out_en & sel_vld & (gnt == IDW'(gi));
    end
  endgenerate

  assign accept = |(s_tvalid & s_tready);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt == IDW'(k)) begin
        sel_data = s_tdata[k*nb +: nb];
        sel_last = s_tlast[k];
      end
    end
  end

  // A new beat overwrites the register even while the old one is being read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_data;
      m_tlast  <= sel_last;
      m_tid    <= gnt;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (NCH=4, 5-byte beats).
// Lock-specific steps are built when ARB_PKT_LOCK_EN is defined.
module tb_stream_rr_arbiter;

  localparam int NB = 40;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [4*NB-1:0] s_tdata;
  logic [3:0]    s_tvalid;
  logic [3:0]    s_tlast;
  logic [3:0]    s_tready;
  logic [NB-1:0] m_tdata;
  logic          m_tlast;
  logic [1:0]    m_tid;
  logic          m_tvalid;
  logic          m_tready;

  int checks = 0;
  int errors = 0;
  int unsigned cnt [4];
  logic [3:0] hs;
  logic [3:0] sready_seen;

  always #5 aclk = ~aclk;

  stream_rr_arbiter #(.n(5), .nb(NB), .NCH(4), .IDW(2)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  // Beat payload: channel number in the top byte, per-channel beat count below.
  function automatic logic [NB-1:0] exp_d(input int ch, input int c);
    return {8'(ch), 32'(c)};
  endfunction

  task automatic set_data();
    for (int k = 0; k < 4; k++) s_tdata[k*NB +: NB] = exp_d(k, int'(cnt[k]));
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    set_data();
  endtask

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input int ch, input int c, input logic lst);
    $display("%s: m_tvalid=%0b m_tid=%0d m_tdata=%h m_tlast=%0b s_tready=%b",
             tag, m_tvalid, m_tid, m_tdata, m_tlast, sready_seen);
    chk({tag, " valid"}, NB'(m_tvalid), NB'(1));
    chk({tag, " tid"}, NB'(m_tid), NB'(ch));
    chk({tag, " data"}, m_tdata, exp_d(ch, c));
    chk({tag, " last"}, NB'(m_tlast), NB'(lst));
  endtask

  // One clock: sample ready/handshake mid-cycle, then advance source payloads.
  task automatic cyc();
    @(negedge aclk);
    hs          = s_tvalid & s_tready;
    sready_seen = s_tready;
    @(posedge aclk);
    #1;
    for (int k = 0; k < 4; k++) if (hs[k]) cnt[k]++;
    set_data();
  endtask

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b1;
    s_tvalid = 4'b1111;
    s_tlast  = 4'b1111;
    clr_cnt();
    repeat (2) @(posedge aclk);
    #1;
    $display("reset: m_tvalid=%0b m_tid=%0d m_tdata=%h s_tready=%b", m_tvalid, m_tid, m_tdata, s_tready);
    chk("rst valid", NB'(m_tvalid), NB'(0));
    chk("rst tid", NB'(m_tid), NB'(0));
    chk("rst data", m_tdata, NB'(0));
    chk("rst tlast", NB'(m_tlast), NB'(0));
    chk("rst sready", NB'(s_tready), NB'(0));
    aresetn = 1'b1;

    // Single-beat packets from every channel: strict rotation from channel 0.
    for (int i = 0; i < 8; i++) begin
      cyc();
      beat("rr", i % 4, i / 4, 1'b1);
    end

`ifdef ARB_PKT_LOCK_EN
    s_tvalid = 4'b0000;
    cyc();
    chk("lock drain", NB'(m_tvalid), NB'(0));
    s_tvalid = 4'b0100;
    s_tlast  = 4'b0000;
    cyc();
    beat("lock b1", 2, 2, 1'b0);
    s_tvalid = 4'b0111;
    cyc();
    chk("lock b2 sready", NB'(sready_seen), NB'(4'b0100));
    beat("lock b2", 2, 3, 1'b0);
    s_tlast = 4'b0100;
    cyc();
    chk("lock b3 sready", NB'(sready_seen), NB'(4'b0100));
    beat("lock b3", 2, 4, 1'b1);
    s_tlast = 4'b0011;
    cyc();
    chk("after lock ch0 sready", NB'(sready_seen), NB'(4'b0001));
    beat("after lock ch0", 0, 2, 1'b1);
    cyc();
    chk("after lock ch1 sready", NB'(sready_seen), NB'(4'b0010));
    beat("after lock ch1", 1, 2, 1'b1);
    s_tvalid = 4'b0000;
`else
    // Beat-level rotation: 4-beat packets from ch0 and ch1 interleave.
    s_tvalid = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      s_tlast = (i / 2 == 3) ? 4'b0011 : 4'b0000;
      cyc();
      beat("interleave", i % 2, 2 + i / 2, (i / 2 == 3));
    end
    s_tvalid = 4'b0000;
`endif

    // Backpressure: output held and all ready low while stalled.
    cyc();
    chk("bp drain", NB'(m_tvalid), NB'(0));
    clr_cnt();
    s_tvalid = 4'b1111;
    s_tlast  = 4'b1111;
    m_tready = 1'b0;
    cyc();
    beat("bp first", 2, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp sready", NB'(sready_seen), NB'(0));
      beat("bp hold", 2, 0, 1'b1);
    end
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      beat("bp release", (3 + i) % 4, ((3 + i) % 4 == 2) ? 1 : 0, 1'b1);
    end
    s_tvalid = 4'b0000;
    cyc();
    chk("bp end drain", NB'(m_tvalid), NB'(0));

`ifdef ARB_PKT_LOCK_EN
    // Locked owner idles mid-packet: the waiting channel stays ungranted.
    s_tvalid = 4'b0010;
    s_tlast  = 4'b0000;
    cyc();
    beat("idle-lock b1", 1, 1, 1'b0);
    s_tvalid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      $display("idle-lock gap: m_tvalid=%0b s_tready=%b", m_tvalid, sready_seen);
      chk("idle-lock gap sready", NB'(sready_seen), NB'(4'b0010));
      chk("idle-lock gap valid", NB'(m_tvalid), NB'(0));
    end
    s_tvalid = 4'b0011;
    s_tlast  = 4'b0010;
    cyc();
    chk("idle-lock b2 sready", NB'(sready_seen), NB'(4'b0010));
    beat("idle-lock b2", 1, 2, 1'b1);
    s_tlast = 4'b0011;
    cyc();
    chk("idle-lock ch0 sready", NB'(sready_seen), NB'(4'b0001));
    beat("idle-lock ch0", 0, 1, 1'b1);
    s_tvalid = 4'b0000;
    cyc();
`endif

    // Asynchronous reset in the middle of a packet.
    clr_cnt();
    s_tvalid = 4'b0100;
    s_tlast  = 4'b0000;
    cyc();
    beat("midrst pre", 2, 0, 1'b0);
    aresetn = 1'b0;
    #1;
    $display("midrst: m_tvalid=%0b m_tid=%0d m_tdata=%h s_tready=%b", m_tvalid, m_tid, m_tdata, s_tready);
    chk("midrst valid", NB'(m_tvalid), NB'(0));
    chk("midrst data", m_tdata, NB'(0));
    chk("midrst tid", NB'(m_tid), NB'(0));
    chk("midrst sready", NB'(s_tready), NB'(0));
    s_tvalid = 4'b1111;
    s_tlast  = 4'b1111;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    cyc();
    beat("post rst ch0", 0, 0, 1'b1);
    cyc();
    beat("post rst ch1", 1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
